// File: rtl/xoodoo_perm_ctrl_if.sv
// Command and word-stream handshake bundle for the Xoodoo permutation sequencer.
interface xoodoo_perm_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_domain;
  logic        cmd_domain_en;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_domain, cmd_domain_en,
    input  cmd_ready,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_domain, cmd_domain_en,
    output cmd_ready,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/xoodoo_perm_ctrl.sv
// Command sequencer for the two-share Xoodoo state register and round datapath.
// Optional macro XOODOO_PERM_CTRL_SQZ_UNMASK_EN: squeeze emits share0^share1 instead of both shares.
module xoodoo_perm_ctrl #(
  parameter int ROUNDS           = 12,
  parameter int CYCLES_PER_ROUND = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  xoodoo_perm_ctrl_if.slave    bus,
  output logic                 reg_init,
  output logic                 reg_start,
  output logic                 reg_running,
  output logic [3:0]           reg_word_index,
  output logic                 reg_word_enable,
  output logic [63:0]          reg_word_in,
  output logic [31:0]          reg_domain,
  output logic                 reg_domain_enable,
  input  logic [63:0]          reg_word_out,
  output logic [3:0]           round_idx,
  output logic                 busy
);

  localparam int              TOTAL    = ROUNDS * CYCLES_PER_ROUND;
  localparam logic [5:0]      LAST_CYC = 6'(TOTAL - 1);
  localparam logic [5:0]      CPR      = 6'(CYCLES_PER_ROUND);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ABSORB, S_DOMAIN, S_PERM, S_SQUEEZE
  } state_t;

  state_t      state, next_state;
  logic [3:0]  word_cnt, word_cnt_nxt;
  logic [5:0]  cyc_cnt, cyc_cnt_nxt;
  logic [3:0]  len_q;
  logic        dom_en_q;
  logic [31:0] domain_q;
  logic [3:0]  cmd_len_sat;

  function automatic logic [3:0] sat_len(input logic [3:0] l);
    return (l > 4'd12) ? 4'd12 : l;
  endfunction

  function automatic logic [63:0] sqz_word(input logic [63:0] w);
`ifdef XOODOO_PERM_CTRL_SQZ_UNMASK_EN
    return {32'd0, w[63:32] ^ w[31:0]};
`else
    return w;
`endif
  endfunction

  assign cmd_len_sat = sat_len(bus.cmd_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word_cnt <= 4'd0;
      cyc_cnt  <= 6'd0;
      len_q    <= 4'd0;
      dom_en_q <= 1'b0;
    end else begin
      state    <= next_state;
      word_cnt <= word_cnt_nxt;
      cyc_cnt  <= cyc_cnt_nxt;
      if (state == S_IDLE && bus.cmd_valid) begin
        len_q    <= cmd_len_sat;
        dom_en_q <= bus.cmd_domain_en;
      end
    end
  end

  // Domain constant is pure data; it is only driven out while in DOMAIN.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.cmd_valid) domain_q <= bus.cmd_domain;
  end

  always_comb begin
    next_state        = state;
    word_cnt_nxt      = word_cnt;
    cyc_cnt_nxt       = cyc_cnt;
    bus.cmd_ready     = 1'b0;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.out_data      = 64'd0;
    reg_init          = 1'b0;
    reg_start         = 1'b0;
    reg_running       = 1'b0;
    reg_word_index    = 4'd0;
    reg_word_enable   = 1'b0;
    reg_word_in       = 64'd0;
    reg_domain        = 32'd0;
    reg_domain_enable = 1'b0;
    round_idx         = 4'd0;

    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'd0: next_state = S_INIT;
            2'd1: begin
              if (cmd_len_sat == 4'd0)
                next_state = bus.cmd_domain_en ? S_DOMAIN : S_IDLE;
              else
                next_state = S_ABSORB;
            end
            2'd2: next_state = S_PERM;
            default: next_state = (cmd_len_sat == 4'd0) ? S_IDLE : S_SQUEEZE;
          endcase
        end
      end

      S_INIT: begin
        reg_init   = 1'b1;
        next_state = S_IDLE;
      end

      S_ABSORB: begin
        bus.in_ready   = 1'b1;
        reg_word_index = word_cnt;
        if (bus.in_valid) begin
          reg_word_enable = 1'b1;
          reg_word_in     = bus.in_data;
          if (word_cnt == len_q - 4'd1) begin
            word_cnt_nxt = 4'd0;
            next_state   = dom_en_q ? S_DOMAIN : S_IDLE;
          end else begin
            word_cnt_nxt = word_cnt + 4'd1;
          end
        end
      end

      S_DOMAIN: begin
        reg_domain_enable = 1'b1;
        reg_domain        = domain_q;
        next_state        = S_IDLE;
      end

      S_PERM: begin
        reg_start   = (cyc_cnt == 6'd0);
        reg_running = (cyc_cnt != 6'd0);
        round_idx   = 4'(cyc_cnt / CPR);
        if (cyc_cnt == LAST_CYC) begin
          cyc_cnt_nxt = 6'd0;
          next_state  = S_IDLE;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 6'd1;
        end
      end

      S_SQUEEZE: begin
        bus.out_valid  = 1'b1;
        reg_word_index = word_cnt;
        // Register read mux is combinational on the index, so data holds while index holds.
        bus.out_data   = sqz_word(reg_word_out);
        if (bus.out_ready) begin
          if (word_cnt == len_q - 4'd1) begin
            word_cnt_nxt = 4'd0;
            next_state   = S_IDLE;
          end else begin
            word_cnt_nxt = word_cnt + 4'd1;
          end
        end
      end

      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_xoodoo_perm_ctrl.sv
// Directed bench for xoodoo_perm_ctrl with a behavioural register read-back model.
module tb_xoodoo_perm_ctrl;
  logic        clk;
  logic        rst;
  logic        reg_init, reg_start, reg_running, reg_word_enable, reg_domain_enable;
  logic [3:0]  reg_word_index;
  logic [63:0] reg_word_in;
  logic [31:0] reg_domain;
  logic [63:0] reg_word_out;
  logic [3:0]  round_idx;
  logic        busy;
  logic [4:0]  strb;
  int          n_vec = 0;
  int          n_err = 0;

  xoodoo_perm_ctrl_if bus();

  xoodoo_perm_ctrl #(.ROUNDS(12), .CYCLES_PER_ROUND(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .reg_init          (reg_init),
    .reg_start         (reg_start),
    .reg_running       (reg_running),
    .reg_word_index    (reg_word_index),
    .reg_word_enable   (reg_word_enable),
    .reg_word_in       (reg_word_in),
    .reg_domain        (reg_domain),
    .reg_domain_enable (reg_domain_enable),
    .reg_word_out      (reg_word_out),
    .round_idx         (round_idx),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign strb = {reg_init, reg_start, reg_running, reg_word_enable, reg_domain_enable};

  function automatic logic [63:0] mdl_word(input logic [3:0] i);
    return {32'hC0DE0000 | {28'd0, i}, 32'h5A000000 | {24'd0, i, 4'h7}};
  endfunction

  function automatic logic [63:0] exp_sqz(input logic [3:0] i);
    logic [63:0] w;
    w = mdl_word(i);
`ifdef XOODOO_PERM_CTRL_SQZ_UNMASK_EN
    return {32'd0, w[63:32] ^ w[31:0]};
`else
    return w;
`endif
  endfunction

  always_comb reg_word_out = mdl_word(reg_word_index);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] len,
                          input logic [31:0] dom, input logic den);
    bus.cmd_valid     = 1'b1;
    bus.cmd_op        = op;
    bus.cmd_len       = len;
    bus.cmd_domain    = dom;
    bus.cmd_domain_en = den;
    #1;
    chk("cmd_ready_before_accept", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_strobes"}, 64'(strb), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_round_idx"}, 64'(round_idx), 64'd0);
    chk({tag, "_io"}, 64'({bus.in_ready, bus.out_valid}), 64'd0);
    chk({tag, "_buses"}, 64'(reg_word_in) | 64'(reg_domain) | 64'(reg_word_index), 64'd0);
  endtask

  initial begin
    int nw;
    int k;
    int cyc;
    logic [63:0] held;

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_len = 4'd0;
    bus.cmd_domain = 32'd0; bus.cmd_domain_en = 1'b0;
    bus.in_data = 64'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // INIT: one reg_init cycle, ready again two cycles after acceptance
    send_cmd(2'd0, 4'd0, 32'd0, 1'b0);
    #1;
    chk("init_strobe", 64'(strb), 64'b10000);
    chk("init_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("init_busy", 64'(busy), 64'd1);
    tick();
    chk_idle("after_init");

    // ABSORB 3 words with a stall between words 1 and 2, then domain 0x3
    send_cmd(2'd1, 4'd3, 32'h00000003, 1'b1);
    for (int w = 0; w < 4; w++) begin
      bus.in_valid = (w != 2);
      bus.in_data  = 64'h1111_0000_2222_0000 + 64'(w);
      #1;
      chk("abs_in_ready", 64'(bus.in_ready), 64'd1);
      if (w == 2) begin
        chk("abs_stall_strobes", 64'(strb), 64'd0);
      end else begin
        chk("abs_strobe", 64'(strb), 64'b00010);
        chk("abs_index", 64'(reg_word_index), 64'((w > 2) ? 2 : w));
        chk("abs_word_in", reg_word_in, 64'h1111_0000_2222_0000 + 64'(w));
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("dom_strobe", 64'(strb), 64'b00001);
    chk("dom_value", 64'(reg_domain), 64'h3);
    chk("dom_no_word", 64'(reg_word_in) | 64'(reg_word_index), 64'd0);
    chk("dom_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk_idle("after_absorb");

    // ABSORB len=0 with domain: straight to the domain cycle
    send_cmd(2'd1, 4'd0, 32'hA5A5_0001, 1'b1);
    #1;
    chk("abs0_dom_strobe", 64'(strb), 64'b00001);
    chk("abs0_dom_value", 64'(reg_domain), 64'hA5A5_0001);
    tick();
    chk_idle("after_abs0");

    // PERMUTE: start once, running 23 cycles, round_idx c/2
    send_cmd(2'd2, 4'd0, 32'd0, 1'b0);
    for (int c = 0; c < 24; c++) begin
      #1;
      chk("perm_strobes", 64'(strb), (c == 0) ? 64'b01000 : 64'b00100);
      chk("perm_round_idx", 64'(round_idx), 64'(c / 2));
      chk("perm_busy", 64'(busy), 64'd1);
      tick();
    end
    chk_idle("after_perm");

    // SQUEEZE 12 words, out_ready alternating 0/1
    send_cmd(2'd3, 4'd12, 32'd0, 1'b0);
    k = 0;
    held = 64'd0;
    for (cyc = 0; cyc < 40 && k < 12; cyc++) begin
      bus.out_ready = (cyc % 2 == 1);
      #1;
      chk("sqz_valid", 64'(bus.out_valid), 64'd1);
      chk("sqz_index", 64'(reg_word_index), 64'(k));
      chk("sqz_data", bus.out_data, exp_sqz(4'(k)));
      if (!bus.out_ready) held = bus.out_data;
      else chk("sqz_stable", bus.out_data, held);
      if (bus.out_ready) k++;
      tick();
    end
    bus.out_ready = 1'b0;
    chk("sqz_words", 64'(k), 64'd12);
    chk("sqz_cycles", 64'(cyc), 64'd24);
    #1;
    chk_idle("after_sqz");

    // ABSORB cmd_len=15 saturates to 12 accepted words
    send_cmd(2'd1, 4'd15, 32'd0, 1'b0);
    nw = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_data = 64'(c);
      #1;
      if (!busy) break;
      if (reg_word_enable) begin
        chk("abs15_index", 64'(reg_word_index), 64'(nw));
        nw++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("abs15_words", 64'(nw), 64'd12);
    #1;
    chk_idle("after_abs15");

    // SQUEEZE len=0: no out_valid, ready at once
    send_cmd(2'd3, 4'd0, 32'd0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk_idle("sqz0");
    tick();
    chk_idle("sqz0_next");
    bus.out_ready = 1'b0;

    // Reset in the middle of PERM at c=7
    send_cmd(2'd2, 4'd0, 32'd0, 1'b0);
    repeat (7) tick();
    #1;
    chk("perm_c7_round", 64'(round_idx), 64'd3);
    chk("perm_c7_strobes", 64'(strb), 64'b00100);
    rst = 1'b1;
    tick();
    chk_idle("mid_perm_reset");
    rst = 1'b0;

    // A fresh PERM after the abort starts again from c=0
    send_cmd(2'd2, 4'd0, 32'd0, 1'b0);
    #1;
    chk("perm2_start", 64'(strb), 64'b01000);
    chk("perm2_round", 64'(round_idx), 64'd0);
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      nw++;
      tick();
    end
    chk("perm2_busy_cycles", 64'(nw), 64'd24);
    chk_idle("after_perm2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
